// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the ASCII 7-segment display block:
//     - state_e      : display FSM states (IDLE / SHOW / GAP)
//     - SEG_*        : bit positions inside an 8-bit segment word
//                      (bits 0-6 = segments a-g, bit 7 = decimal point)
//     - seg_decode() : ASCII code -> active-high segment pattern
// ----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Segment a sits in bit 0 and g in bit 6; b-f follow in order between them.
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Letters are case-insensitive; lowercase input lights the decimal point so
    // the viewer can still tell the two cases apart.
    function automatic logic [7:0] seg_decode(input logic [7:0] code);
        logic       lower;
        logic [7:0] upper;
        logic [6:0] glyph;
        logic [7:0] seg;
        lower = (code >= 8'h61) && (code <= 8'h7A);
        upper = lower ? (code - 8'h20) : code;
        case (upper)
            8'h20: glyph = 7'h00; // space
            8'h30: glyph = 7'h3F; // 0
            8'h31: glyph = 7'h06; // 1
            8'h32: glyph = 7'h5B; // 2
            8'h33: glyph = 7'h4F; // 3
            8'h34: glyph = 7'h66; // 4
            8'h35: glyph = 7'h6D; // 5
            8'h36: glyph = 7'h7D; // 6
            8'h37: glyph = 7'h07; // 7
            8'h38: glyph = 7'h7F; // 8
            8'h39: glyph = 7'h6F; // 9
            8'h41: glyph = 7'h77; // A
            8'h42: glyph = 7'h7C; // b
            8'h43: glyph = 7'h39; // C
            8'h44: glyph = 7'h5E; // d
            8'h45: glyph = 7'h79; // E
            8'h46: glyph = 7'h71; // F
            8'h47: glyph = 7'h3D; // G
            8'h48: glyph = 7'h76; // H
            8'h49: glyph = 7'h30; // I
            8'h4A: glyph = 7'h1E; // J
            8'h4B: glyph = 7'h75; // K
            8'h4C: glyph = 7'h38; // L
            8'h4D: glyph = 7'h15; // M
            8'h4E: glyph = 7'h54; // n
            8'h4F: glyph = 7'h3F; // O
            8'h50: glyph = 7'h73; // P
            8'h51: glyph = 7'h67; // q
            8'h52: glyph = 7'h50; // r
            8'h53: glyph = 7'h6D; // S
            8'h54: glyph = 7'h78; // t
            8'h55: glyph = 7'h3E; // U
            8'h56: glyph = 7'h1C; // v
            8'h57: glyph = 7'h2A; // W
            8'h58: glyph = 7'h76; // X
            8'h59: glyph = 7'h6E; // y
            8'h5A: glyph = 7'h5B; // Z
            default: glyph = 7'h40; // dash for anything undisplayable
        endcase
        seg              = SEG_BLANK;
        seg[SEG_G:SEG_A] = glyph;
        seg[SEG_DP]      = lower;
        return seg;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// ----------------------------------------------------------------------------
// char_fifo
//   Small synchronous FIFO buffering characters in front of the display FSM.
//   The head entry is visible combinationally on data_o whenever empty_o is 0.
//
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (empties the buffer)
//   push_i   in   write data_i (ignored when full)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   drop the head entry (ignored when empty)
//   data_o   out  head entry
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   count_o  out  number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module char_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so the pointers wrap modulo DEPTH by overflow.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and
    // pointers decide which entries are valid, and resetting the array would
    // only cost flops with reset logic instead of plain storage.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ascii_seg_display.sv
// ----------------------------------------------------------------------------
// ascii_seg_display
//   Shows a stream of ASCII characters one at a time on a 7-segment display.
//   Each character is held for hold_cycles clocks (minimum 1), followed by a
//   blank gap of GAP_CYCLES clocks so that repeated letters stay distinct.
//
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   char_in      in   ASCII character
//   char_valid   in   char_in holds a character
//   char_ready   out  buffer can take a character this cycle
//   hold_cycles  in   display time per character, sampled when it is popped
//   seg_out      out  segments a-g in bits 0-6, dp in bit 7, active-high
//   busy         out  showing, in a gap, or holding buffered characters
// ----------------------------------------------------------------------------
module ascii_seg_display
    import seg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [7:0]        seg_out,
    output logic              busy
);

    localparam int CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]        seg_q, seg_d;

    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    // Readiness depends only on the fill level, never on a same-cycle pop.
    assign char_ready = !fifo_full && !rst;
    assign push       = char_valid && char_ready;

    char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (char_in),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            seg_q      <= seg_d;
        end
    end

    // Next-state logic; a pop happens exactly on entry to SHOW.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SHOW;
                    pop     = 1'b1;
                end
            end
            ST_SHOW: begin
                if (hold_cnt_q == '0) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (!fifo_empty) begin
                        state_d = ST_SHOW;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / counter logic. The hold counter is loaded with H-1 at the pop
    // so a later change on hold_cycles cannot stretch the current character.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        seg_d      = seg_q;
        if (pop) begin
            seg_d      = seg_decode(fifo_head);
            hold_cnt_d = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
        end else if (state_q == ST_SHOW) begin
            if (hold_cnt_q == '0) begin
                seg_d     = SEG_BLANK;
                gap_cnt_d = GAP_LAST;
            end else begin
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
        end else if (state_q == ST_GAP) begin
            if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
    end

    assign seg_out = seg_q;
    assign busy    = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ascii_seg_display.sv
module tb_ascii_seg_display;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int HW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid = 1'b0;
    logic          char_ready;
    logic [HW-1:0] hold_cycles = '0;
    logic [7:0]    seg_out;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ascii_seg_display #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_W     (HW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .hold_cycles (hold_cycles),
        .seg_out     (seg_out),
        .busy        (busy)
    );

    // Reference glyphs (g..a) for digits and letters.
    localparam logic [6:0] DIGITS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] LETTERS [26] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                                           7'h3D, 7'h76, 7'h30, 7'h1E, 7'h75, 7'h38,
                                           7'h15, 7'h54, 7'h3F, 7'h73, 7'h67, 7'h50,
                                           7'h6D, 7'h78, 7'h3E, 7'h1C, 7'h2A, 7'h76,
                                           7'h6E, 7'h5B};

    function automatic logic [7:0] ref_pattern(input logic [7:0] c);
        int code;
        code = int'(c);
        if (code >= 48 && code <= 57)  return {1'b0, DIGITS[code - 48]};
        if (code >= 65 && code <= 90)  return {1'b0, LETTERS[code - 65]};
        if (code >= 97 && code <= 122) return {1'b1, LETTERS[code - 97]};
        if (code == 32)                return 8'h00;
        return 8'h40;
    endfunction

    // Model: pending characters, plus the stream of display values still owed
    // for the character currently on screen (H copies of its glyph, GAP blanks).
    logic [7:0] mq[$];
    logic [7:0] stream[$];
    logic [7:0] exp_seg = 8'h00;
    logic       exp_busy = 1'b0;
    logic       exp_ready = 1'b0;

    // Per-cycle logs: {seg_out, busy, char_ready} observed vs. expected.
    logic [9:0] got_log[$];
    logic [9:0] exp_log[$];
    bit         acc_log[$];

    task automatic clear_logs();
        got_log.delete();
        exp_log.delete();
        acc_log.delete();
    endtask

    // Advance one clock, stepping the model with the inputs present at the edge.
    task automatic tick(output bit acc);
        logic [7:0] c;
        logic [7:0] p;
        int         h;
        bit         consumed;
        acc      = 1'b0;
        consumed = 1'b0;
        if (rst) begin
            mq.delete();
            stream.delete();
            exp_seg = 8'h00;
        end else begin
            acc = char_valid && (mq.size() < DEPTH);
            if (stream.size() == 0 && mq.size() != 0) begin
                c = mq.pop_front();
                h = (hold_cycles == '0) ? 1 : int'(hold_cycles);
                p = ref_pattern(c);
                for (int i = 0; i < h; i++)   stream.push_back(p);
                for (int i = 0; i < GAP; i++) stream.push_back(8'h00);
            end
            if (stream.size() != 0) begin
                exp_seg  = stream.pop_front();
                consumed = 1'b1;
            end else begin
                exp_seg = 8'h00;
            end
            if (acc) mq.push_back(char_in);
        end
        exp_busy = consumed || (mq.size() != 0);
        @(posedge clk);
        #1;
        exp_ready = !rst && (mq.size() < DEPTH);
        got_log.push_back({seg_out, busy, char_ready});
        exp_log.push_back({exp_seg, exp_busy, exp_ready});
        acc_log.push_back(acc);
    endtask

    // Offer the characters of s in order (holding each until taken) for n ticks.
    task automatic drive_string(input string s, input int n_ticks);
        int idx;
        bit acc;
        idx = 0;
        for (int t = 0; t < n_ticks; t++) begin
            if (idx < s.len()) begin
                char_in    = s[idx];
                char_valid = 1'b1;
            end else begin
                char_valid = 1'b0;
            end
            tick(acc);
            if (acc) idx++;
        end
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit acc;
        rst        = 1'b1;
        char_valid = 1'b0;
        tick(acc);
        tick(acc);
        checks++;
        if ({seg_out, busy, char_ready} !== 10'h000) begin
            errors++;
            $display("FAIL reset_held got seg=%02h busy=%b ready=%b exp seg=00 busy=0 ready=0",
                     seg_out, busy, char_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({seg_out, busy, char_ready} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release got seg=%02h busy=%b ready=%b exp seg=00 busy=0 ready=1",
                     seg_out, busy, char_ready);
        end
    endtask

    task automatic test_single_t();
        logic [7:0] exp_seq [6] = '{8'h78, 8'h78, 8'h78, 8'h00, 8'h00, 8'h00};
        logic [9:0] g;
        clear_logs();
        hold_cycles = 16'd3;
        drive_string("T", 7);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL single_t_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        g = got_log[0];
        checks++;
        if ({g[9:2], g[1]} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL single_t_accept got seg=%02h busy=%b exp seg=00 busy=1", g[9:2], g[1]);
        end
        for (int k = 0; k < 6; k++) begin
            g = got_log[k + 1];
            checks++;
            if (g[9:2] !== exp_seq[k]) begin
                errors++;
                $display("FAIL single_t_seq k=%0d got=%02h exp=%02h", k, g[9:2], exp_seq[k]);
            end
        end
        g = got_log[6];
        checks++;
        if (g[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_t_idle got busy=%b exp busy=0", g[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [8] = '{8'hF7, 8'hF7, 8'h00, 8'h00, 8'hF7, 8'hF7, 8'h00, 8'h00};
        logic [9:0] g;
        clear_logs();
        hold_cycles = 16'd2;
        drive_string("aa", 10);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL b2b_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            g = got_log[k + 1];
            checks++;
            if (g[9:2] !== exp_seq[k]) begin
                errors++;
                $display("FAIL b2b_seq k=%0d got=%02h exp=%02h", k, g[9:2], exp_seq[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        string      s;
        logic [7:0] shown[$];
        logic [7:0] prev;
        logic [9:0] g;
        int         n_acc;
        s = "HELLO1";
        clear_logs();
        hold_cycles = 16'd10;
        drive_string(s, 110);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL bp_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        n_acc = 0;
        foreach (acc_log[i]) begin
            if (acc_log[i]) begin
                n_acc++;
                g = got_log[i];
                if (n_acc == 4) begin
                    checks++;
                    if (g[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_ready_after_4th got=%b exp=1", g[0]);
                    end
                end
                if (n_acc == 5) begin
                    checks++;
                    if (g[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_ready_after_5th got=%b exp=0", g[0]);
                    end
                end
            end
        end
        prev = 8'h00;
        foreach (got_log[i]) begin
            g = got_log[i];
            if (prev == 8'h00 && g[9:2] != 8'h00) shown.push_back(g[9:2]);
            prev = g[9:2];
        end
        checks++;
        if (shown.size() != s.len()) begin
            errors++;
            $display("FAIL bp_shown_count got=%0d exp=%0d", shown.size(), s.len());
        end else begin
            for (int k = 0; k < s.len(); k++) begin
                checks++;
                if (shown[k] !== ref_pattern(s[k])) begin
                    errors++;
                    $display("FAIL bp_order k=%0d got=%02h exp=%02h", k, shown[k], ref_pattern(s[k]));
                end
            end
        end
        g = got_log[got_log.size() - 1];
        checks++;
        if (g[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained got busy=%b exp busy=0", g[1]);
        end
    endtask

    task automatic test_zero_hold();
        logic [7:0] exp_seq [9] = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00};
        logic [9:0] g;
        clear_logs();
        hold_cycles = 16'd0;
        drive_string("0 ?", 12);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL zero_hold_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        for (int k = 0; k < 9; k++) begin
            g = got_log[k + 1];
            checks++;
            if (g[9:2] !== exp_seq[k]) begin
                errors++;
                $display("FAIL zero_hold_seq k=%0d got=%02h exp=%02h", k, g[9:2], exp_seq[k]);
            end
        end
    endtask

    task automatic test_reset_mid_show();
        bit         acc;
        logic [9:0] g;
        clear_logs();
        hold_cycles = 16'd10;
        drive_string("WXYZ", 6);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        #1;
        checks++;
        if ({seg_out, busy, char_ready} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_release got seg=%02h busy=%b ready=%b exp seg=00 busy=0 ready=1",
                     seg_out, busy, char_ready);
        end
        drive_string("", 40);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL mid_reset_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        for (int i = 7; i < got_log.size(); i++) begin
            g = got_log[i];
            checks++;
            if (g[9:2] !== 8'h00) begin
                errors++;
                $display("FAIL mid_reset_stale cycle=%0d got=%02h exp=00", i, g[9:2]);
            end
        end
    endtask

    task automatic test_hold_change();
        logic [7:0] exp_seq [10] = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h73,
                                     8'h00, 8'h00, 8'h3E, 8'h00, 8'h00};
        logic [9:0] g;
        clear_logs();
        hold_cycles = 16'd5;
        drive_string("PU", 3);
        hold_cycles = 16'd1;
        drive_string("", 10);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL hold_chg_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            g = got_log[k + 1];
            checks++;
            if (g[9:2] !== exp_seq[k]) begin
                errors++;
                $display("FAIL hold_chg_seq k=%0d got=%02h exp=%02h", k, g[9:2], exp_seq[k]);
            end
        end
    endtask

    task automatic test_random();
        bit         acc;
        logic [9:0] g;
        clear_logs();
        for (int t = 0; t < 500; t++) begin
            rst        = ($urandom_range(0, 199) == 0);
            char_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       char_in = 8'(8'h30 + $urandom_range(0, 9));
                1:       char_in = 8'(8'h41 + $urandom_range(0, 25));
                2:       char_in = 8'(8'h61 + $urandom_range(0, 25));
                3:       char_in = 8'h20;
                default: char_in = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 7) == 0) hold_cycles = HW'($urandom_range(0, 4));
            tick(acc);
        end
        rst        = 1'b0;
        char_valid = 1'b0;
        for (int t = 0; t < 60; t++) tick(acc);
        foreach (got_log[i]) begin
            checks++;
            if (got_log[i] !== exp_log[i]) begin
                errors++;
                $display("FAIL random_model cycle=%0d got=%03h exp=%03h", i, got_log[i], exp_log[i]);
            end
        end
        g = got_log[got_log.size() - 1];
        checks++;
        if (g[1] !== 1'b0) begin
            errors++;
            $display("FAIL random_drained got busy=%b exp busy=0", g[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_t();
        test_back_to_back();
        test_backpressure();
        test_zero_hold();
        test_reset_mid_show();
        test_hold_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascii_seg_display.md
ASCII_SEG_DISPLAY -- requirements
Module: ascii_seg_display

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the input buffer depth in characters (power of two, at least 2).
REQ-003 Parameter HOLD_W, default 16, SHALL set the width of hold_cycles.
REQ-004 Parameter GAP_CYCLES, default 2, SHALL set the blank-gap length in clocks (at least 1).
REQ-005 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 char_in  input  8  SHALL carry the ASCII character from the upstream string generator.
REQ-008 char_valid  input  1  SHALL indicate that char_in holds a character.
REQ-009 char_ready  output  1  SHALL be high when the buffer can accept a character.
REQ-010 hold_cycles  input  HOLD_W  SHALL give the display time per character in clocks.
REQ-011 seg_out  output  8  SHALL drive the 7-segment display: bits 0-6 = segments a-g, bit 7 = dp, all active-high.
REQ-012 busy  output  1  SHALL be high while a character is displayed, in a gap, or buffered.

Function
REQ-013 A character SHALL be accepted on a rising edge where char_valid && char_ready.
REQ-014 char_ready SHALL be high exactly when the buffer holds fewer than FIFO_DEPTH characters; it SHALL NOT depend on a same-cycle pop (full stays not-ready).
REQ-015 Accepted characters SHALL be displayed in arrival order, with none lost or duplicated.
REQ-016 The FSM SHALL have three states: IDLE, SHOW and GAP.
REQ-017 Transition IDLE->SHOW: on the first edge where the buffer is non-empty, the block SHALL pop the head character and load seg_out with its pattern.
REQ-018 Latency: a character accepted at edge E into an empty buffer while in IDLE SHALL appear on seg_out after edge E+1.
REQ-019 SHOW SHALL last exactly H clocks, where H = hold_cycles sampled at the pop edge, and H = 1 when hold_cycles = 0.
REQ-020 A change to hold_cycles during SHOW SHALL NOT affect the character being shown.
REQ-021 SHOW->GAP: seg_out SHALL be 0x00 for exactly GAP_CYCLES clocks, so repeated letters are distinguishable.
REQ-022 At the end of GAP the FSM SHALL enter SHOW directly (popping the next character) if the buffer is non-empty, and IDLE otherwise.
REQ-023 In IDLE, seg_out SHALL be 0x00.
REQ-024 Decode table, bits 6..0 (g..a):
  - '0'-'9': standard digits ('0' = 0x3F).
  - 'A'-'Z' and 'a'-'z': case-insensitive standard approximations ('A' = 0x77, 'T' = 0x78).
  - space (0x20): 0x00.
  - any other code: 0x40 (dash).
REQ-025 dp (bit 7) SHALL be 1 during SHOW only when the displayed character is lowercase (0x61-0x7A).
REQ-026 A push to a full buffer SHALL be impossible by handshake; a push and a pop in the same cycle on a non-full, non-empty buffer SHALL leave the count unchanged.
REQ-027 The buffer read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 busy SHALL equal (state != IDLE) || (count != 0).

Reset
REQ-029 While rst is high at an edge, the block SHALL clear the FSM to IDLE, empty the buffer, zero the hold and gap counters, and set seg_out = 0x00.
REQ-030 char_ready SHALL be 0 while rst is high and 1 on the first cycle after rst is released.
REQ-031 busy SHALL be 0 on the first cycle after rst is released.
REQ-032 Reset asserted mid-SHOW or mid-GAP SHALL discard the current character and all buffered characters.

Structure
REQ-033 A shared package seg_pkg SHALL hold:
  - the FSM state enum;
  - segment bit-position constants;
  - the ASCII-to-segment decode function.
REQ-034 The buffer SHALL be a separate sub-module, char_fifo, with push/pop/full/empty/count ports, parameterised by width and depth.

Verification
REQ-035 Accept 'T' (0x54) with hold_cycles=3 after reset -> seg_out=0x78 for exactly 3 clocks starting the edge after acceptance, then 0x00 for 2 clocks, then IDLE with busy=0.
REQ-036 Push "aa" back-to-back with hold_cycles=2 -> seg_out sequence 0xF7,0xF7,0x00,0x00,0xF7,0xF7,0x00,0x00.
REQ-037 Push 6 characters with char_valid held high, hold_cycles=10 -> char_ready drops after the 5th acceptance (1 popped + 4 buffered), and all 6 are displayed in order.
REQ-038 Push '0', ' ', '?' with hold_cycles=0 -> each shown for 1 clock: 0x3F, 0x00, 0x40, each followed by the 2-clock gap.
REQ-039 Assert rst during SHOW with 3 characters buffered -> next cycle seg_out=0x00, busy=0, char_ready=1, and no stale character is displayed afterwards.
REQ-040 Change hold_cycles from 5 to 1 mid-SHOW -> the current character still shows 5 clocks, and the next character shows 1 clock.
